// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Runs 32 shift-add multiply or restoring divide steps on operand
// magnitudes, then sign-corrects and commits the result to HI/LO in FIX.
//
// Handshake: there is no ready; `start` is a one-shot request sampled only
// while IDLE (busy low). Once accepted, `busy` stays high until the result
// is committed, and `done` pulses for exactly one cycle alongside the first
// cycle in which HI/LO show the new result.
module mdu_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;     // mult: {partial, multiplier}; div: {rem, quo}
  logic [31:0] a_q, a_d;         // multiplicand or divisor magnitude
  logic        neg_res_q, neg_res_d;  // product / quotient sign
  logic        neg_rem_q, neg_rem_d;  // dividend sign (remainder sign)
  logic        div0_q, div0_d;
  logic        is_div_q, is_div_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, done_q, done_d;

  // Operand decode: op[1] selects divide, op[0] selects unsigned.
  logic        rs_neg, rt_neg;
  logic [31:0] rs_mag, rt_mag;
  logic [32:0] msum;
  logic [32:0] dtrial;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign rs_neg = ~op[0] & rs_val[31];
  assign rt_neg = ~op[0] & rt_val[31];
  assign rs_mag = rs_neg ? 32'(-rs_val) : rs_val;
  assign rt_mag = rt_neg ? 32'(-rt_val) : rt_val;

  // Shift-add step: add multiplicand into the upper half when the current
  // multiplier bit is set, then shift the whole accumulator right.
  assign msum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);

  // Restoring step: borrow out (bit 32) means the trial subtraction failed.
  assign dtrial = {acc_q[63:32], acc_q[31]} - {1'b0, a_q};

  assign prod_fix = neg_res_q ? 64'(-acc_q) : acc_q;
  assign quo_fix  = neg_res_q ? 32'(-acc_q[31:0]) : acc_q[31:0];
  // For a zero divisor the remainder equals the dividend magnitude, so the
  // same sign correction restores the original rs_val.
  assign rem_fix  = neg_rem_q ? 32'(-acc_q[63:32]) : acc_q[63:32];

  // Next-state logic for the sequencer and HI/LO writes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    is_div_d  = is_div_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (start) begin
          cnt_d     = 5'd0;
          neg_res_d = rs_neg ^ rt_neg;
          neg_rem_d = rs_neg;
          div0_d    = (rt_val == 32'd0);
          is_div_d  = op[1];
          if (op[1]) begin
            a_d     = rt_mag;
            acc_d   = {32'd0, rs_mag};
            state_d = S_DIV;
          end else begin
            a_d     = rs_mag;
            acc_d   = {32'd0, rt_mag};
            state_d = S_MUL;
          end
        end else begin
          if (mthi) hi_d = wdata;
          if (mtlo) lo_d = wdata;
        end
      end
      S_MUL: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = {msum, acc_q[31:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) state_d = S_FIX;
        end
      end
      S_DIV: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!dtrial[32]) acc_d = {dtrial[31:0], acc_q[30:0], 1'b1};
          else             acc_d = {acc_q[62:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(ITER - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = div0_q ? 32'hFFFF_FFFF : quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      a_q       <= 32'd0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      is_div_q  <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl. Inputs change on the falling edge and
// outputs are observed on the falling edge, half a cycle after the DUT edge.
module tb_mdu_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  mdu_ctrl #(.ITER(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .mthi      (mthi),
    .mtlo      (mtlo),
    .wdata     (wdata),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    mthi = 1'b0; mtlo = 1'b0; wdata = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %h want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %h want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
  endtask

  task automatic test_mthi_mtlo();
    mthi = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    mthi = 1'b0;
    n_checks++; if (hi !== 32'h1234_5678) begin n_fail++; $display("FAIL mthi_hi got %h want 12345678", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL mthi_lo got %h want 0", lo); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mthi_done got %h want 0", done); end
    // Both writes together.
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hAABB_CCDD;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++; if (hi !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL both_hi got %h want aabbccdd", hi); end
    n_checks++; if (lo !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL both_lo got %h want aabbccdd", lo); end
    // Flush in IDLE takes priority over mthi/mtlo.
    mthi = 1'b1; mtlo = 1'b1; flush = 1'b1; wdata = 32'h0;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; flush = 1'b0;
    n_checks++; if (hi !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL flush_mthi_hi got %h want aabbccdd", hi); end
    n_checks++; if (lo !== 32'hAABB_CCDD) begin n_fail++; $display("FAIL flush_mtlo_lo got %h want aabbccdd", lo); end
  endtask

  // Issue one op at the current falling edge and wait for its commit.
  // Returns at the falling edge where done is high, so a following call
  // issues start into the earliest accepting edge.
  task automatic run_op(input string name, input logic [1:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit poke_mt);
    int cycles;
    int dones;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_low got %h want 0", name, done); end
    cycles = 0;
    dones  = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      dones += int'(done);
      if (poke_mt && cycles == 5) begin
        mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
      end else begin
        mthi = 1'b0; mtlo = 1'b0;
      end
      @(negedge clk);
    end
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++; if (cycles != 33) begin n_fail++; $display("FAIL %s_busy_cycles got %0d want 33", name, cycles); end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL %s_early_done got %0d want 0", name, dones); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL %s_done got %h want 1", name, done); end
    n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL %s_hi got %h want %h", name, hi, exp_hi); end
    n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL %s_lo got %h want %h", name, lo, exp_lo); end
  endtask

  task automatic test_multu();
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL multu_done_deassert got %h want 0", done); end
  endtask

  task automatic test_mult();
    run_op("mult_neg", 2'b00, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    @(negedge clk);
    run_op("mult_ign_mt", 2'b00, 32'd5, 32'd5, 32'h0, 32'd25, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_div();
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    @(negedge clk);
    run_op("divu_zero", 2'b11, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op("div_zero_s", 2'b10, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0);
    // 100 / -7 = -14 remainder 2
    run_op("b2b_second", 2'b10, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_div_overflow();
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    @(negedge clk);
  endtask

  task automatic test_flush();
    int dones;
    start = 1'b1; op = 2'b10; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_pre_busy got %h want 1", busy); end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy got %h want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL flush_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL flush_lo got %h want 80000000", lo); end
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      dones += int'(done);
      @(negedge clk);
    end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL flush_no_done got %0d want 0", dones); end
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL flush_lo_later got %h want 80000000", lo); end
  endtask

  task automatic test_reset_mid();
    start = 1'b1; op = 2'b10; rs_val = 32'h8000_0000; rt_val = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %h want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done got %h want 0", done); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rst_mid_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_mid_lo got %h want 0", lo); end
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_post_idle got busy=%h done=%h want 0 0", busy, done); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rst_post_lo got %h want 0", lo); end
  endtask

  initial begin
    test_reset();
    test_mthi_mtlo();
    test_multu();
    test_mult();
    test_div();
    test_back_to_back();
    test_div_overflow();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
